// File: rtl/pcs_pkg.sv
// Shared types and constants for the 64b/66b block-lock engine.
//   lock_fsm_e : per-lane lock state
//   SYNC_DATA / SYNC_CTRL : the two legal sync-header patterns
//   sh_valid() : true when a 2-bit header is one of the legal patterns
package pcs_pkg;

  typedef enum logic [1:0] {
    LOCK_INIT,
    TEST,
    SLIP,
    WAIT
  } lock_fsm_e;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  function automatic logic sh_valid(input logic [1:0] head);
    return (head == SYNC_DATA) || (head == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/pcs_sync_rx_lane.sv
// Single-lane block-lock FSM with sync-header window counters.
//   clk, reset : clock, synchronous active-high reset
//   valid      : header beat valid (signal_ok and gearbox beat valid)
//   head       : sync header of this beat
//   slip       : one-cycle slip request to the gearbox (registered)
//   lock       : rx_block_lock (registered)
module pcs_sync_rx_lane
  import pcs_pkg::*;
#(
  parameter int HEAD_W       = 2,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid,
  input  logic [HEAD_W-1:0] head,
  output logic              slip,
  output logic              lock
);

  localparam int CNT_W   = $clog2(SH_CNT_MAX + 1);
  localparam int INVLD_W = $clog2(SH_INVLD_MAX + 1);
  localparam int WAIT_W  = (SLIP_WAIT > 0) ? $clog2(SLIP_WAIT + 1) : 1;

  lock_fsm_e          st;
  logic [CNT_W-1:0]   sh_cnt;
  logic [INVLD_W-1:0] sh_invld_cnt;
  logic [WAIT_W-1:0]  wait_cnt;

  logic               bad;
  logic               do_test;
  logic [CNT_W-1:0]   cnt_nx;
  logic [INVLD_W-1:0] invld_nx;
  logic [WAIT_W-1:0]  wait_nx;

  // The beat arriving while SLIP is shown is already the first post-slip beat:
  // it is the first ignored beat, or a counted beat when no settle window exists.
  always_comb begin
    bad      = !sh_valid(head);
    cnt_nx   = sh_cnt + CNT_W'(1);
    invld_nx = sh_invld_cnt + INVLD_W'(bad);
    wait_nx  = wait_cnt + WAIT_W'(1);
    do_test  = (st == LOCK_INIT) || (st == TEST) || ((st == SLIP) && (SLIP_WAIT == 0));
  end

  always_ff @(posedge clk) begin
    if (reset || !valid) begin
      // Signal loss behaves like reset for this lane, without a slip pulse.
      st           <= LOCK_INIT;
      sh_cnt       <= '0;
      sh_invld_cnt <= '0;
      wait_cnt     <= '0;
      slip         <= 1'b0;
      lock         <= 1'b0;
    end else begin
      slip <= 1'b0;
      if (do_test) begin
        if (bad && (!lock || (invld_nx == INVLD_W'(SH_INVLD_MAX)))) begin
          st           <= SLIP;
          slip         <= 1'b1;
          lock         <= 1'b0;
          sh_cnt       <= '0;
          sh_invld_cnt <= '0;
          wait_cnt     <= '0;
        end else if (cnt_nx == CNT_W'(SH_CNT_MAX)) begin
          if (invld_nx == '0) lock <= 1'b1;
          st           <= TEST;
          sh_cnt       <= '0;
          sh_invld_cnt <= '0;
        end else begin
          st           <= TEST;
          sh_cnt       <= cnt_nx;
          sh_invld_cnt <= invld_nx;
        end
      end else if (wait_nx == WAIT_W'(SLIP_WAIT)) begin
        st       <= TEST;
        wait_cnt <= '0;
      end else begin
        st       <= WAIT;
        wait_cnt <= wait_nx;
      end
    end
  end

endmodule

// File: rtl/pcs_sync_rx_lanes.sv
// Multi-lane 64b/66b block-lock engine: one independent lock FSM per lane.
//   clk, reset : clock, synchronous active-high reset
//   valid_i    : per-lane header valid
//   head_i     : lane l header at [l*HEAD_W +: HEAD_W]
//   slip_v_o   : per-lane one-cycle slip request
//   lock_v_o   : per-lane rx_block_lock
//   lock_all_o : registered AND of lock_v_o
module pcs_sync_rx_lanes
  import pcs_pkg::*;
#(
  parameter int LANE_N       = 1,
  parameter int HEAD_W       = 2,
  parameter int SH_CNT_MAX   = 64,
  parameter int SH_INVLD_MAX = 16,
  parameter int SLIP_WAIT    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LANE_N-1:0]        valid_i,
  input  logic [LANE_N*HEAD_W-1:0] head_i,
  output logic [LANE_N-1:0]        slip_v_o,
  output logic [LANE_N-1:0]        lock_v_o,
  output logic                     lock_all_o
);

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    pcs_sync_rx_lane #(
      .HEAD_W      (HEAD_W),
      .SH_CNT_MAX  (SH_CNT_MAX),
      .SH_INVLD_MAX(SH_INVLD_MAX),
      .SLIP_WAIT   (SLIP_WAIT)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .valid(valid_i[l]),
      .head (head_i[l*HEAD_W +: HEAD_W]),
      .slip (slip_v_o[l]),
      .lock (lock_v_o[l])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) lock_all_o <= 1'b0;
    else       lock_all_o <= &lock_v_o;
  end

endmodule

// File: tb/tb_pcs_sync_rx_lanes.sv
// Bench for pcs_sync_rx_lanes: a 4-lane SLIP_WAIT=2 build and a 1-lane
// SLIP_WAIT=0 build, both checked every cycle against a beat-level model.
module tb_pcs_sync_rx_lanes;

  localparam int CNT_MAX = 64;
  localparam int INV_MAX = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] va;
  logic [7:0] ha;
  logic [3:0] slip_a, lock_a;
  logic       all_a;
  logic [0:0] vb;
  logic [1:0] hb;
  logic [0:0] slip_b, lock_b;
  logic       all_b;

  pcs_sync_rx_lanes #(
    .LANE_N(4), .HEAD_W(2), .SH_CNT_MAX(CNT_MAX), .SH_INVLD_MAX(INV_MAX), .SLIP_WAIT(2)
  ) dut_a (
    .clk(clk), .reset(rst), .valid_i(va), .head_i(ha),
    .slip_v_o(slip_a), .lock_v_o(lock_a), .lock_all_o(all_a)
  );

  pcs_sync_rx_lanes #(
    .LANE_N(1), .HEAD_W(2), .SH_CNT_MAX(CNT_MAX), .SH_INVLD_MAX(INV_MAX), .SLIP_WAIT(0)
  ) dut_b (
    .clk(clk), .reset(rst), .valid_i(vb), .head_i(hb),
    .slip_v_o(slip_b), .lock_v_o(lock_b), .lock_all_o(all_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Model: lanes 0..3 belong to dut_a, lane 4 to dut_b.
  // n/b = headers/invalid headers in current window, skip = beats still to ignore.
  int n[5], b[5], skip[5];
  bit lk[5], sl[5];
  int sw[5] = '{2, 2, 2, 2, 0};

  function automatic void ref_clear(int l);
    n[l] = 0; b[l] = 0; skip[l] = 0; lk[l] = 0; sl[l] = 0;
  endfunction

  function automatic void ref_beat(int l, bit v, logic [1:0] h);
    bit bad;
    bad = !((h == 2'b01) || (h == 2'b10));
    sl[l] = 0;
    if (!v) begin
      ref_clear(l);
    end else if (skip[l] > 0) begin
      skip[l]--;
    end else begin
      n[l]++;
      if (bad) b[l]++;
      if (bad && (!lk[l] || b[l] == INV_MAX)) begin
        sl[l] = 1; lk[l] = 0; n[l] = 0; b[l] = 0; skip[l] = sw[l];
      end else if (n[l] == CNT_MAX) begin
        if (b[l] == 0) lk[l] = 1;
        n[l] = 0; b[l] = 0;
      end
    end
  endfunction

  task automatic tick(input string tag);
    bit prev_a, prev_b;
    logic [3:0] el, es;
    prev_a = lk[0] & lk[1] & lk[2] & lk[3];
    prev_b = lk[4];
    @(posedge clk);
    #1;
    if (rst) begin
      for (int l = 0; l < 5; l++) ref_clear(l);
      prev_a = 0;
      prev_b = 0;
    end else begin
      for (int l = 0; l < 4; l++) ref_beat(l, va[l], ha[l*2 +: 2]);
      ref_beat(4, vb[0], hb);
    end
    el = {lk[3], lk[2], lk[1], lk[0]};
    es = {sl[3], sl[2], sl[1], sl[0]};
    check({tag, "_slip_a"}, 32'(slip_a), 32'(es));
    check({tag, "_lock_a"}, 32'(lock_a), 32'(el));
    check({tag, "_all_a"},  32'(all_a),  32'(prev_a));
    check({tag, "_slip_b"}, 32'(slip_b), 32'(sl[4]));
    check({tag, "_lock_b"}, 32'(lock_b), 32'(lk[4]));
    check({tag, "_all_b"},  32'(all_b),  32'(prev_b));
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic set_clean();
    for (int l = 0; l < 4; l++) ha[l*2 +: 2] = good_hdr();
    hb = good_hdr();
    va = 4'hF;
    vb = 1'b1;
  endtask

  initial begin
    rst = 1'b1; va = '0; ha = '0; vb = '0; hb = '0;
    tick("rst");
    tick("rst");
    check("rst_lock", 32'(lock_a), 32'h0);
    check("rst_slip", 32'(slip_a), 32'h0);
    check("rst_all",  32'(all_a),  32'h0);
    rst = 1'b0;

    // Lock acquire from LOCK_INIT: the first valid beat counts.
    for (int i = 1; i <= 64; i++) begin
      set_clean();
      tick("t1");
      if (i == 63) check("t1_pre", 32'(lock_a), 32'h0);
      if (i == 64) begin
        check("t1_lock", 32'(lock_a), 32'hF);
        check("t1_all_lag", 32'(all_a), 32'h0);
      end
    end
    set_clean();
    tick("t1b");
    check("t1_all", 32'(all_a), 32'h1);

    // Unlocked slip on lane 0, beat 5.
    rst = 1'b1; tick("t2r"); rst = 1'b0;
    for (int i = 1; i <= 71; i++) begin
      set_clean();
      if (i == 5) ha[1:0] = 2'b11;
      tick("t2");
      if (i == 5)  check("t2_slip",  32'(slip_a), 32'h1);
      if (i == 6)  check("t2_pulse", 32'(slip_a), 32'h0);
      if (i == 70) check("t2_early", 32'(lock_a[0]), 32'h0);
      if (i == 71) check("t2_lock",  32'(lock_a[0]), 32'h1);
    end
    // Finish the current window of lanes 1..3 (second window ends at beat 128).
    for (int i = 0; i < 57; i++) begin
      set_clean();
      tick("t3pre");
    end

    // Lock tolerance on lane 1: 15 invalid headers hold, the 16th drops.
    for (int i = 1; i <= 48; i++) begin
      set_clean();
      if (i % 3 == 0) ha[3:2] = bad_hdr();
      tick("t3");
      if (i % 3 == 0) begin
        if (i < 48) begin
          check("t3_hold",   32'(lock_a[1]), 32'h1);
          check("t3_noslip", 32'(slip_a[1]), 32'h0);
        end else begin
          check("t3_drop", 32'(lock_a[1]), 32'h0);
          check("t3_slip", 32'(slip_a[1]), 32'h1);
        end
      end
    end

    // Signal loss on lane 2.
    set_clean();
    va[2] = 1'b0;
    tick("t4");
    check("t4_lock",   32'(lock_a[2]), 32'h0);
    check("t4_noslip", 32'(slip_a), 32'h0);
    check("t4_lane0",  32'(lock_a[0]), 32'h1);
    check("t4_lane3",  32'(lock_a[3]), 32'h1);

    // Random traffic: rare invalid headers, rare signal loss, rare reset.
    for (int i = 0; i < 800; i++) begin
      for (int l = 0; l < 4; l++) begin
        va[l] = ($urandom_range(0, 99) != 0);
        ha[l*2 +: 2] = ($urandom_range(0, 149) == 0) ? bad_hdr() : good_hdr();
      end
      vb[0] = ($urandom_range(0, 99) != 0);
      hb = ($urandom_range(0, 149) == 0) ? bad_hdr() : good_hdr();
      rst = ($urandom_range(0, 399) == 0);
      tick("rnd");
    end
    rst = 1'b0;

    // Reset mid-window, then a full fresh window; SLIP_WAIT=0 build counts the post-slip beat.
    rst = 1'b1; tick("t6r"); rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      set_clean();
      tick("t6a");
    end
    rst = 1'b1;
    set_clean();
    tick("t6_rst");
    check("t6_zero_lock", 32'(lock_a), 32'h0);
    check("t6_zero_slip", 32'(slip_a), 32'h0);
    check("t6_zero_all",  32'(all_a),  32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 65; i++) begin
      set_clean();
      if (i == 1) hb = 2'b11;
      tick("t6");
      if (i == 1)  check("t6_b_slip", 32'(slip_b), 32'h1);
      if (i == 63) check("t6_pre", 32'(lock_a), 32'h0);
      if (i == 64) begin
        check("t6_relock",  32'(lock_a), 32'hF);
        check("t6_b_early", 32'(lock_b), 32'h0);
      end
      if (i == 65) check("t6_b_lock", 32'(lock_b), 32'h1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
